// File: rtl/rf_wb_arbiter_pkg.sv
// Shared writeback/regfile constants: write-enable polarity, default widths, requester ids.
package rf_wb_arbiter_pkg;

    localparam logic REGWE_WRITE = 1'b1;
    localparam logic REGWE_READ  = 1'b0;

    localparam int N_REQ_DEF = 3;
    localparam int XLEN_DEF  = 32;
    localparam int REGW_DEF  = 5;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_LSU = 2'd1,
        WB_MDU = 2'd2
    } wb_src_e;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback requesters, regfile write port and decode scoreboard query, bundled.
// Parameters must match those of the rf_wb_arbiter instance the bundle connects to.
interface rf_wb_arbiter_if
    import rf_wb_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int XLEN  = XLEN_DEF,
    parameter int REGW  = REGW_DEF
) ();

    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ*REGW-1:0] req_rd;
    logic [N_REQ*XLEN-1:0] req_data;

    logic                  rf_we;
    logic [REGW-1:0]       rf_wr;
    logic [XLEN-1:0]       rf_wd;

    logic                  sb_set;
    logic [REGW-1:0]       sb_set_rd;
    logic [REGW-1:0]       rs1;
    logic [REGW-1:0]       rs2;
    logic                  rs1_busy;
    logic                  rs2_busy;
    logic [31:0]           busy_vec;

    // Requesters and decode side
    modport master (
        output req_valid, req_rd, req_data, sb_set, sb_set_rd, rs1, rs2,
        input  req_ready, rf_we, rf_wr, rf_wd, rs1_busy, rs2_busy, busy_vec
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_rd, req_data, sb_set, sb_set_rd, rs1, rs2,
        output req_ready, rf_we, rf_wr, rf_wd, rs1_busy, rs2_busy, busy_vec
    );

endinterface

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// N-way round-robin pick: first valid at or after i_ptr, wrapping; purely combinational.
// One-hot grant plus encoded index; o_any low when nobody is valid.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_valid,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);

    int          w_sum;
    logic [PW-1:0] w_k;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_sum   = 0;
        w_k     = '0;
        for (int off = 0; off < N; off++) begin
            w_sum = int'(i_ptr) + off;
            if (w_sum >= N) w_sum = w_sum - N;
            w_k = PW'(w_sum);
            if (!o_any && i_valid[w_k]) begin
                o_any      = 1'b1;
                o_grant[w_k] = 1'b1;
                o_idx      = w_k;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin share of the regfile write port plus 32-entry pending-write scoreboard.
// Grant is same-cycle combinational; write lands on rf_* one cycle after accept, one per cycle.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int XLEN  = XLEN_DEF,
    parameter int REGW  = REGW_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    rf_wb_arbiter_if.slave bus
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0]    r_rr_ptr;
    logic             r_we;
    logic [REGW-1:0]  r_wr;
    logic [XLEN-1:0]  r_wd;
    logic [31:0]      r_busy;

    logic [N_REQ-1:0] w_grant;
    logic [PW-1:0]    w_idx;
    logic             w_any;
    logic [REGW-1:0]  w_sel_rd;
    logic [XLEN-1:0]  w_sel_dat;
    logic             w_wr_ok;
    logic [31:0]      w_busy_nxt;

    rr_arbiter #(
        .N  (N_REQ),
        .PW (PW)
    ) u_rr (
        .i_valid (bus.req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Grant is forced low while reset is asserted so nobody sees a phantom accept.
    assign bus.req_ready = w_grant & {N_REQ{rst_n}};

    always_comb begin
        w_sel_rd  = '0;
        w_sel_dat = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_rd  = bus.req_rd[i*REGW +: REGW];
                w_sel_dat = bus.req_data[i*XLEN +: XLEN];
            end
        end
    end

    assign w_wr_ok = w_any && (w_sel_rd != '0);

    // Set is applied after clear so a same-edge redispatch keeps the entry pending.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr_ok)                          w_busy_nxt[w_sel_rd]      = 1'b0;
        if (bus.sb_set && bus.sb_set_rd != '0) w_busy_nxt[bus.sb_set_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
            r_we     <= REGWE_READ;
            r_wr     <= '0;
            r_wd     <= '0;
            r_busy   <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_any)
                r_rr_ptr <= (w_idx == PW'(N_REQ - 1)) ? '0 : w_idx + PW'(1);
            if (w_wr_ok) begin
                r_we <= REGWE_WRITE;
                r_wr <= w_sel_rd;
                r_wd <= w_sel_dat;
            end else begin
                r_we <= REGWE_READ;
            end
        end
    end

    assign bus.rf_we    = r_we;
    assign bus.rf_wr    = r_wr;
    assign bus.rf_wd    = r_wd;
    assign bus.busy_vec = r_busy;

    assign bus.rs1_busy = (bus.rs1 != '0) && r_busy[bus.rs1];
    assign bus.rs2_busy = (bus.rs2 != '0) && r_busy[bus.rs2];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Table-driven bench for rf_wb_arbiter with a queue of expected regfile writes.
module tb_rf_wb_arbiter;
    import rf_wb_arbiter_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rf_wb_arbiter_if bus ();

    rf_wb_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0]  v;
        logic [14:0] rd;
        logic [95:0] dat;
        logic        set;
        logic [4:0]  set_rd;
        logic [2:0]  exp_rdy;
    } vec_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
    } wr_t;

    wr_t         exp_q[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic [4:0]  m_wr   = '0;
    logic [31:0] m_wd   = '0;
    logic [31:0] m_busy = '0;
    vec_t        tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] dgen(input logic [4:0] rd, input int i);
        return 32'hC0DE_0000 | (32'(rd) << 4) | 32'(i);
    endfunction

    function automatic vec_t mkv(input logic [2:0] v, input logic [4:0] r0, input logic [4:0] r1,
                                 input logic [4:0] r2, input logic set, input logic [4:0] set_rd,
                                 input logic [2:0] exp_rdy);
        vec_t t;
        t.v       = v;
        t.rd      = {r2, r1, r0};
        t.dat     = {dgen(r2, 2), dgen(r1, 1), dgen(r0, 0)};
        t.set     = set;
        t.set_rd  = set_rd;
        t.exp_rdy = exp_rdy;
        return t;
    endfunction

    // Drive one cycle, check same-cycle grant, then check the registered write after the edge.
    task automatic step(input vec_t t);
        int          g;
        logic [4:0]  grd;
        wr_t         e;
        wr_t         got;
        @(negedge clk);
        bus.req_valid = t.v;
        bus.req_rd    = t.rd;
        bus.req_data  = t.dat;
        bus.sb_set    = t.set;
        bus.sb_set_rd = t.set_rd;
        #1;
        chk("req_ready", 32'(bus.req_ready), 32'(t.exp_rdy));
        g = -1;
        for (int i = 0; i < 3; i++) if (t.exp_rdy[i]) g = i;
        grd  = '0;
        e.we = 1'b0;
        if (g >= 0) begin
            grd = t.rd[g*5 +: 5];
            if (grd != 5'd0) begin
                e.we = 1'b1;
                m_wr = grd;
                m_wd = t.dat[g*32 +: 32];
                m_busy[grd] = 1'b0;
            end
        end
        if (t.set && t.set_rd != 5'd0) m_busy[t.set_rd] = 1'b1;
        e.wr = m_wr;
        e.wd = m_wd;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = {bus.rf_we, bus.rf_wr, bus.rf_wd};
        if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL queue: got empty expected an entry");
        end else begin
            e = exp_q.pop_front();
            chk("rf_we", 32'(got.we), 32'(e.we));
            chk("rf_wr", 32'(got.wr), 32'(e.wr));
            chk("rf_wd", got.wd, e.wd);
        end
        chk("busy_vec", bus.busy_vec, m_busy);
    endtask

    task automatic query(input logic [4:0] a, input logic [4:0] b, input logic ea, input logic eb);
        bus.rs1 = a;
        bus.rs2 = b;
        #1;
        chk("rs1_busy", 32'(bus.rs1_busy), 32'(ea));
        chk("rs2_busy", 32'(bus.rs2_busy), 32'(eb));
    endtask

    initial begin
        vec_t t;
        bus.req_valid = 3'b111;
        bus.req_rd    = '0;
        bus.req_data  = '0;
        bus.sb_set    = 1'b0;
        bus.sb_set_rd = '0;
        bus.rs1       = '0;
        bus.rs2       = '0;

        // Reset state, with requests pending so ready must stay low
        @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_we", 32'(bus.rf_we), 32'd0);
        chk("rst_wr", 32'(bus.rf_wr), 32'd0);
        chk("rst_wd", bus.rf_wd, 32'd0);
        chk("rst_busy", bus.busy_vec, 32'd0);
        @(negedge clk);
        bus.req_valid = '0;
        rst_n = 1'b1;

        // Round-robin, single write, x0 drop and set/clear traffic
        tbl[0] = mkv(3'b111, 5'd1, 5'd2, 5'd3, 1'b0, 5'd0,  3'b001);
        tbl[1] = mkv(3'b111, 5'd1, 5'd2, 5'd3, 1'b1, 5'd2,  3'b010);
        tbl[2] = mkv(3'b111, 5'd1, 5'd2, 5'd3, 1'b0, 5'd0,  3'b100);
        tbl[3] = mkv(3'b111, 5'd1, 5'd2, 5'd3, 1'b0, 5'd0,  3'b001);
        tbl[4] = mkv(3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd31, 3'b000);
        tbl[5] = mkv(3'b010, 5'd0, 5'd5, 5'd0, 1'b0, 5'd0,  3'b010);
        tbl[5].dat[63:32] = 32'hDEAD_BEEF;
        tbl[6] = mkv(3'b100, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0,  3'b100);
        tbl[6].dat[95:64] = 32'h0000_1234;
        tbl[7] = mkv(3'b101, 5'd4, 5'd9, 5'd2, 1'b0, 5'd0,  3'b001);
        tbl[8] = mkv(3'b101, 5'd4, 5'd9, 5'd2, 1'b0, 5'd0,  3'b100);
        tbl[9] = mkv(3'b110, 5'd4, 5'd6, 5'd2, 1'b0, 5'd0,  3'b010);
        for (int i = 0; i < 10; i++) step(tbl[i]);

        // Scoreboard set, query, clear, and same-edge set+clear
        step(mkv(3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd10, 3'b000));
        query(5'd10, 5'd0, 1'b1, 1'b0);
        query(5'd31, 5'd2, 1'b1, 1'b0);
        t = mkv(3'b001, 5'd10, 5'd0, 5'd0, 1'b0, 5'd0, 3'b001);
        t.dat[31:0] = 32'h0A0A_0A0A;
        step(t);
        query(5'd10, 5'd0, 1'b0, 1'b0);
        step(mkv(3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd10, 3'b000));
        step(mkv(3'b010, 5'd0, 5'd10, 5'd0, 1'b1, 5'd10, 3'b010));
        query(5'd10, 5'd10, 1'b1, 1'b1);

        // Asynchronous reset in the middle of a pending transfer
        @(negedge clk);
        bus.req_valid = 3'b001;
        bus.req_rd    = 15'd7;
        bus.req_data  = 96'h5555_AAAA;
        bus.sb_set    = 1'b1;
        bus.sb_set_rd = 5'd7;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        chk("mid_rst_we", 32'(bus.rf_we), 32'd0);
        chk("mid_rst_wr", 32'(bus.rf_wr), 32'd0);
        chk("mid_rst_wd", bus.rf_wd, 32'd0);
        chk("mid_rst_busy", bus.busy_vec, 32'd0);
        m_wr   = '0;
        m_wd   = '0;
        m_busy = '0;
        @(posedge clk);
        #1;
        chk("rst_hold_we", 32'(bus.rf_we), 32'd0);
        chk("rst_hold_busy", bus.busy_vec, 32'd0);
        @(negedge clk);
        bus.req_valid = '0;
        bus.sb_set    = 1'b0;
        rst_n = 1'b1;
        step(mkv(3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 3'b000));
        step(mkv(3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 3'b000));
        step(mkv(3'b110, 5'd0, 5'd3, 5'd4, 1'b0, 5'd0, 3'b010));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
